// File: rtl/sdrc_wb_traffic_gen.sv
// Wishbone burst traffic generator/checker for the SDRAM controller port:
// writes a data pattern in bursts, reads it back and reports mismatches.
module sdrc_wb_traffic_gen #(
  parameter int          AW      = 26,
  parameter int          DW      = 32,
  parameter int          MAX_BL  = 8,
  parameter int          NB_W    = 16,
  parameter logic [31:0] SEED    = 32'hACE1_0001,
  parameter int          TIMEOUT = 1024
) (
  input  logic              sys_clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [AW-1:0]     cfg_base_addr,
  input  logic [NB_W-1:0]   cfg_num_bursts,
  input  logic [4:0]        cfg_burst_len,
  input  logic [1:0]        cfg_mode,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_cnt,
  output logic [AW-1:0]     first_err_addr,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [AW-1:0]     wb_addr_o,
  output logic [DW/8-1:0]   wb_sel_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic [2:0]        wb_cti_o,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic              wb_ack_i
);

  localparam int            SW         = DW / 8;
  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] STEP       = AW'(SW);
  localparam logic [31:0]   LFSR_TAPS  = 32'h8020_0003;
  localparam logic [DW-1:0] WALK0      = DW'(1);

  typedef enum logic [2:0] {IDLE, WR_BEAT, WR_GAP, RD_BEAT, RD_GAP, FIN} state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  function automatic logic [DW-1:0] pattern(input logic [1:0]    mode,
                                            input logic [AW-1:0] a,
                                            input logic [31:0]   lf,
                                            input logic [DW-1:0] walk);
    logic [DW+AW-1:0] ext;
    logic [DW-1:0]    av;
    ext = {{DW{1'b0}}, a};
    av  = ext[DW-1:0];
    case (mode)
      2'd0:    return av;
      2'd1:    return lf[DW-1:0];
      2'd2:    return walk;
      default: return ~av;
    endcase
  endfunction

  function automatic logic [4:0] clamp_bl(input logic [4:0] bl);
    if (bl == 5'd0)         return 5'd1;
    if (bl > 5'(MAX_BL))    return 5'(MAX_BL);
    return bl;
  endfunction

  state_t            state_q, state_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic              timeout_q, timeout_d, aborted_q, aborted_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [AW-1:0]     first_err_addr_q, first_err_addr_d;
  logic              cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic [2:0]        cti_q, cti_d;
  logic [AW-1:0]     base_q, base_d;
  logic [NB_W-1:0]   nb_q, nb_d, burst_q, burst_d;
  logic [4:0]        bl_q, bl_d, beat_q, beat_d;
  logic [1:0]        mode_q, mode_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [DW-1:0]     walk_q, walk_d;
  logic [TW-1:0]     tmo_q, tmo_d;

  logic ack, last_beat, last_burst, in_beat, present;

  always_comb begin
    state_d          = state_q;
    busy_d           = busy_q;
    done_d           = done_q;
    pass_d           = pass_q;
    timeout_d        = timeout_q;
    aborted_d        = aborted_q;
    err_cnt_d        = err_cnt_q;
    first_err_addr_d = first_err_addr_q;
    addr_d           = addr_q;
    base_d           = base_q;
    nb_d             = nb_q;
    bl_d             = bl_q;
    mode_d           = mode_q;
    burst_d          = burst_q;
    beat_d           = beat_q;
    lfsr_d           = lfsr_q;
    walk_d           = walk_q;

    ack        = wb_ack_i & stb_q;
    last_beat  = (beat_q == bl_q - 5'd1);
    last_burst = (burst_q == nb_q - NB_W'(1));
    in_beat    = (state_q == WR_BEAT) || (state_q == RD_BEAT);

    case (state_q)
      IDLE, FIN: begin
        // FIN is entered with busy still set; the verdict lands one cycle later
        if (busy_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (err_cnt_q == 16'd0) && !timeout_q && !aborted_q;
        end else if (start) begin
          base_d           = cfg_base_addr;
          nb_d             = cfg_num_bursts;
          bl_d             = clamp_bl(cfg_burst_len);
          mode_d           = cfg_mode;
          busy_d           = 1'b1;
          done_d           = 1'b0;
          pass_d           = 1'b0;
          timeout_d        = 1'b0;
          aborted_d        = 1'b0;
          err_cnt_d        = 16'd0;
          first_err_addr_d = '0;
          addr_d           = cfg_base_addr;
          lfsr_d           = SEED;
          walk_d           = WALK0;
          beat_d           = 5'd0;
          burst_d          = '0;
          state_d          = (cfg_num_bursts == '0) ? FIN : WR_BEAT;
        end
      end
      WR_BEAT, RD_BEAT: begin
        if (ack) begin
          if (state_q == RD_BEAT && wb_dat_i != pattern(mode_q, addr_q, lfsr_q, walk_q)) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            if (err_cnt_q == 16'd0)    first_err_addr_d = addr_q;
          end
          addr_d = addr_q + STEP;
          lfsr_d = lfsr_step(lfsr_q);
          walk_d = {walk_q[DW-2:0], walk_q[DW-1]};
          beat_d = last_beat ? 5'd0 : beat_q + 5'd1;
          if (last_beat) begin
            if (state_q == WR_BEAT) state_d = WR_GAP;
            else                    state_d = last_burst ? FIN : RD_GAP;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = FIN;
        end
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = FIN;
        end
      end
      WR_GAP: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = FIN;
        end else if (last_burst) begin
          burst_d = '0;
          addr_d  = base_q;
          lfsr_d  = SEED;
          walk_d  = WALK0;
          state_d = RD_BEAT;
        end else begin
          burst_d = burst_q + NB_W'(1);
          state_d = WR_BEAT;
        end
      end
      RD_GAP: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = FIN;
        end else begin
          burst_d = burst_q + NB_W'(1);
          state_d = RD_BEAT;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered: derive them from where the FSM is heading
    present = (state_d == WR_BEAT) || (state_d == RD_BEAT);
    cyc_d   = present;
    stb_d   = present;
    we_d    = (state_d == WR_BEAT);
    sel_d   = present ? {SW{1'b1}} : {SW{1'b0}};
    dat_d   = (state_d == WR_BEAT) ? pattern(mode_d, addr_d, lfsr_d, walk_d) : '0;
    if (!present || bl_d == 5'd1)    cti_d = 3'b000;
    else if (beat_d == bl_d - 5'd1)  cti_d = 3'b111;
    else                             cti_d = 3'b010;
    tmo_d = (present && in_beat && !ack) ? tmo_q + TW'(1) : '0;
  end

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= IDLE;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      timeout_q        <= 1'b0;
      aborted_q        <= 1'b0;
      err_cnt_q        <= 16'd0;
      first_err_addr_q <= '0;
      cyc_q            <= 1'b0;
      stb_q            <= 1'b0;
      we_q             <= 1'b0;
      addr_q           <= '0;
      sel_q            <= '0;
      dat_q            <= '0;
      cti_q            <= 3'b000;
      base_q           <= '0;
      nb_q             <= '0;
      bl_q             <= 5'd0;
      mode_q           <= 2'd0;
      burst_q          <= '0;
      beat_q           <= 5'd0;
      lfsr_q           <= 32'd0;
      walk_q           <= '0;
      tmo_q            <= '0;
    end else begin
      state_q          <= state_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      timeout_q        <= timeout_d;
      aborted_q        <= aborted_d;
      err_cnt_q        <= err_cnt_d;
      first_err_addr_q <= first_err_addr_d;
      cyc_q            <= cyc_d;
      stb_q            <= stb_d;
      we_q             <= we_d;
      addr_q           <= addr_d;
      sel_q            <= sel_d;
      dat_q            <= dat_d;
      cti_q            <= cti_d;
      base_q           <= base_d;
      nb_q             <= nb_d;
      bl_q             <= bl_d;
      mode_q           <= mode_d;
      burst_q          <= burst_d;
      beat_q           <= beat_d;
      lfsr_q           <= lfsr_d;
      walk_q           <= walk_d;
      tmo_q            <= tmo_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_addr_q;
  assign wb_cyc_o       = cyc_q;
  assign wb_stb_o       = stb_q;
  assign wb_we_o        = we_q;
  assign wb_addr_o      = addr_q;
  assign wb_sel_o       = sel_q;
  assign wb_dat_o       = dat_q;
  assign wb_cti_o       = cti_q;

endmodule
